// File: rtl/fifo_param_sync.sv
// Parameterised single-clock FIFO with optional first-word-fall-through read,
// almost-full/empty thresholds, occupancy/high-water reporting and sticky error flags.
module fifo_param_sync #(
    parameter int WIDTH           = 8,
    parameter int ENTRIES         = 4,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = ENTRIES - 1,
    parameter int ALMOST_EMPTY_TH = 1,
    localparam int CW             = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_clear_err,
    input  logic             in_read_ctrl,
    input  logic             in_write_ctrl,
    input  logic [WIDTH-1:0] in_write_data,
    output logic [WIDTH-1:0] out_read_data,
    output logic             out_read_valid,
    output logic             out_is_full,
    output logic             out_is_empty,
    output logic             out_almost_full,
    output logic             out_almost_empty,
    output logic [CW-1:0]    out_count,
    output logic [CW-1:0]    out_high_water,
    output logic             out_overflow,
    output logic             out_underflow
);
    localparam int PW = $clog2(ENTRIES);
    localparam int unsigned N = ENTRIES;
    localparam logic [CW-1:0] DEPTH    = CW'(ENTRIES);
    localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] LAST_PTR = PW'(ENTRIES - 1);

    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_param_sync: WIDTH must be 1 or more");
    end
    if (ENTRIES < 2) begin : g_bad_entries
        $error("fifo_param_sync: ENTRIES must be 2 or more");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > ENTRIES) begin : g_bad_af
        $error("fifo_param_sync: ALMOST_FULL_TH out of range 1..ENTRIES");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > ENTRIES - 1) begin : g_bad_ae
        $error("fifo_param_sync: ALMOST_EMPTY_TH out of range 0..ENTRIES-1");
    end

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next, high_water;
    logic             full, empty, almost_full, almost_empty;
    logic             overflow, underflow;
    logic             rd_acc, wr_acc;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_acc     = in_read_ctrl & ~empty;
        wr_acc     = in_write_ctrl & (~full | rd_acc);
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= in_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            high_water   <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count        <= count_next;
            full         <= (count_next == DEPTH);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_TH);
            almost_empty <= (count_next <= AE_TH);
            if (in_clear_err) begin
                high_water <= count_next;
            end else if (count_next > high_water) begin
                high_water <= count_next;
            end
            // A fresh error in the clearing cycle keeps the flag set.
            overflow  <= (in_write_ctrl & ~wr_acc) | (overflow & ~in_clear_err);
            underflow <= (in_read_ctrl & ~rd_acc) | (underflow & ~in_clear_err);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign out_read_data  = empty ? '0 : mem[rd_ptr];
        assign out_read_valid = ~empty;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata;
        logic             rvalid;
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata  <= '0;
                rvalid <= 1'b0;
            end else begin
                rvalid <= rd_acc;
                if (rd_acc) rdata <= mem[rd_ptr];
            end
        end
        assign out_read_data  = rdata;
        assign out_read_valid = rvalid;
    end

    assign out_is_full      = full;
    assign out_is_empty     = empty;
    assign out_almost_full  = almost_full;
    assign out_almost_empty = almost_empty;
    assign out_count        = count;
    assign out_high_water   = high_water;
    assign out_overflow     = overflow;
    assign out_underflow    = underflow;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= DEPTH);
    a_full_empty:  assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_ptr_rel:     assert property (@(posedge clk) disable iff (rst)
                       32'(wr_ptr) == (32'(rd_ptr) + 32'(count)) % N);

    for (genvar i = 0; i <= ENTRIES; i++) begin : g_cov
        c_count: cover property (@(posedge clk) count == CW'(i));
    end
endmodule

// File: tb/tb_fifo_param_sync.sv
// Bench for fifo_param_sync: a registered-read and an FWFT instance share one
// stimulus stream and are checked against a queue-based model plus directed vectors.
module tb_fifo_param_sync;
    localparam int W  = 8;
    localparam int E  = 5;
    localparam int CW = $clog2(E + 1);

    logic clk = 1'b0;
    logic rst, clr, rd, wr;
    logic [W-1:0] wdata;

    logic [W-1:0]  rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, full_a, full_b, empty_a, empty_b;
    logic          af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, udf_a, udf_b;
    logic [CW-1:0] count_a, count_b, hw_a, hw_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_param_sync #(.WIDTH(W), .ENTRIES(E), .FWFT(0)) u_dut_reg (
        .clk(clk), .rst(rst), .in_clear_err(clr), .in_read_ctrl(rd),
        .in_write_ctrl(wr), .in_write_data(wdata),
        .out_read_data(rdata_a), .out_read_valid(rvalid_a),
        .out_is_full(full_a), .out_is_empty(empty_a),
        .out_almost_full(af_a), .out_almost_empty(ae_a),
        .out_count(count_a), .out_high_water(hw_a),
        .out_overflow(ovf_a), .out_underflow(udf_a)
    );

    fifo_param_sync #(.WIDTH(W), .ENTRIES(E), .FWFT(1)) u_dut_fwft (
        .clk(clk), .rst(rst), .in_clear_err(clr), .in_read_ctrl(rd),
        .in_write_ctrl(wr), .in_write_data(wdata),
        .out_read_data(rdata_b), .out_read_valid(rvalid_b),
        .out_is_full(full_b), .out_is_empty(empty_b),
        .out_almost_full(af_b), .out_almost_empty(ae_b),
        .out_count(count_b), .out_high_water(hw_b),
        .out_overflow(ovf_b), .out_underflow(udf_b)
    );

    // Reference model: the FIFO contents as a plain queue.
    logic [W-1:0] mq[$];
    int           m_hw;
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit rdc, input bit wrc,
                              input logic [W-1:0] d);
        bit ra, wa;
        if (r) begin
            mq.delete();
            m_hw = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
        end else begin
            ra = rdc && (mq.size() != 0);
            wa = wrc && ((mq.size() < E) || ra);
            m_ovf = (wrc && !wa) || (m_ovf && !c);
            m_udf = (rdc && !ra) || (m_udf && !c);
            m_rv  = ra;
            if (ra) m_rd = mq.pop_front();
            if (wa) mq.push_back(d);
            if (c) m_hw = mq.size();
            else if (mq.size() > m_hw) m_hw = mq.size();
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("m_count_a", 32'(count_a), 32'(n));
        chk("m_count_b", 32'(count_b), 32'(n));
        chk("m_full_a",  32'(full_a),  32'(n == E));
        chk("m_full_b",  32'(full_b),  32'(n == E));
        chk("m_empty_a", 32'(empty_a), 32'(n == 0));
        chk("m_empty_b", 32'(empty_b), 32'(n == 0));
        chk("m_af_a",    32'(af_a),    32'(n >= E - 1));
        chk("m_af_b",    32'(af_b),    32'(n >= E - 1));
        chk("m_ae_a",    32'(ae_a),    32'(n <= 1));
        chk("m_ae_b",    32'(ae_b),    32'(n <= 1));
        chk("m_hw_a",    32'(hw_a),    32'(m_hw));
        chk("m_hw_b",    32'(hw_b),    32'(m_hw));
        chk("m_ovf_a",   32'(ovf_a),   32'(m_ovf));
        chk("m_ovf_b",   32'(ovf_b),   32'(m_ovf));
        chk("m_udf_a",   32'(udf_a),   32'(m_udf));
        chk("m_udf_b",   32'(udf_b),   32'(m_udf));
        chk("m_rvalid_a", 32'(rvalid_a), 32'(m_rv));
        chk("m_rdata_a",  32'(rdata_a),  32'(m_rd));
        chk("m_rvalid_b", 32'(rvalid_b), 32'(n != 0));
        chk("m_rdata_b",  32'(rdata_b),  (n != 0) ? 32'(mq[0]) : 32'h0);
    endtask

    task automatic step(input bit r, input bit c, input bit rdc, input bit wrc,
                        input logic [W-1:0] d);
        rst = r; clr = c; rd = rdc; wr = wrc; wdata = d;
        @(posedge clk);
        model_edge(r, c, rdc, wrc, d);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] d;
        int         cnt;
        bit         full;
        bit         af;
        bit         empty;
        bit         rv;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, 1, 8'h11, 1, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 8'h22, 2, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 1, 8'h33, 3, 0, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 1, 8'h44, 4, 0, 1, 0, 0, 8'h00};
        tbl[4]  = '{0, 1, 8'h55, 5, 1, 1, 0, 0, 8'h00};
        tbl[5]  = '{1, 0, 8'h00, 4, 0, 1, 0, 1, 8'h11};
        tbl[6]  = '{1, 0, 8'h00, 3, 0, 0, 0, 1, 8'h22};
        tbl[7]  = '{1, 0, 8'h00, 2, 0, 0, 0, 1, 8'h33};
        tbl[8]  = '{1, 0, 8'h00, 1, 0, 0, 0, 1, 8'h44};
        tbl[9]  = '{1, 0, 8'h00, 0, 0, 0, 1, 1, 8'h55};
        tbl[10] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h55};

        rst = 1'b1; clr = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0;

        // Reset state
        step(1, 0, 0, 0, 8'h00);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_ae",    32'(ae_a), 1);
        chk("rst_rdata", 32'(rdata_a), 0);

        // Fill and drain through the directed table
        for (int i = 0; i < 11; i++) begin
            step(0, 0, tbl[i].rd, tbl[i].wr, tbl[i].d);
            chk($sformatf("tbl%0d_count", i), 32'(count_a), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i),  32'(full_a),  32'(tbl[i].full));
            chk($sformatf("tbl%0d_af", i),    32'(af_a),    32'(tbl[i].af));
            chk($sformatf("tbl%0d_empty", i), 32'(empty_a), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_rv", i),    32'(rvalid_a), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata_a), 32'(tbl[i].rdata));
        end

        // Wrap-around: 12 write/read pairs take the pointers round twice
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 8'(i));
            step(0, 0, 1, 0, 8'h00);
            chk($sformatf("wrap%0d_data", i), 32'(rdata_a), 32'(i));
        end
        chk("wrap_hw", 32'(hw_a), 1);

        // Simultaneous read/write while full, then overflow and clear
        step(1, 0, 0, 0, 8'h00);
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, 8'(i));
        step(0, 0, 1, 1, 8'h66);
        chk("full_rw_count", 32'(count_a), 5);
        chk("full_rw_ovf",   32'(ovf_a), 0);
        chk("full_rw_data",  32'(rdata_a), 32'h01);
        step(0, 0, 0, 1, 8'hEE);
        chk("ovf_count", 32'(count_a), 5);
        chk("ovf_set",   32'(ovf_a), 1);
        step(0, 0, 0, 0, 8'h00);
        chk("ovf_sticky", 32'(ovf_a), 1);
        step(0, 1, 0, 0, 8'h00);
        chk("ovf_clear", 32'(ovf_a), 0);
        chk("clr_hw",    32'(hw_a), 5);
        step(0, 1, 0, 1, 8'hEF);
        chk("ovf_set_wins", 32'(ovf_a), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'h00);
        chk("drain_data", 32'(rdata_a), 32'h66);

        // Simultaneous read/write while empty
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 8'h77);
        chk("empty_rw_count", 32'(count_a), 1);
        chk("empty_rw_udf",   32'(udf_a), 1);
        chk("empty_rw_rv",    32'(rvalid_a), 0);

        // FWFT visibility
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'hA5);
        chk("fwft_data",  32'(rdata_b), 32'hA5);
        chk("fwft_valid", 32'(rvalid_b), 1);
        step(0, 0, 1, 0, 8'h00);
        chk("fwft_pop_data",  32'(rdata_b), 0);
        chk("fwft_pop_empty", 32'(empty_b), 1);
        chk("reg_pop_data",   32'(rdata_a), 32'hA5);

        // Reset mid-stream at count 3 discards contents and flags
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'hC0 + 8'(i));
        chk("pre_rst_count", 32'(count_a), 3);
        step(1, 0, 1, 1, 8'hDD);
        chk("midrst_count", 32'(count_a), 0);
        chk("midrst_empty", 32'(empty_a), 1);
        chk("midrst_hw",    32'(hw_a), 0);
        chk("midrst_udf",   32'(udf_a), 0);
        chk("midrst_ovf",   32'(ovf_a), 0);
        step(0, 0, 0, 1, 8'h99);
        chk("midrst_fwft", 32'(rdata_b), 32'h99);
        step(0, 0, 1, 0, 8'h00);
        chk("midrst_new", 32'(rdata_a), 32'h99);

        // Randomised traffic with alternating fill/drain bias
        for (int k = 0; k < 2000; k++) begin
            bit b, r, c, rq, wq;
            b  = ((k / 64) % 2) == 0;
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 15) == 0);
            wq = ($urandom_range(0, 3) < (b ? 3 : 1));
            rq = ($urandom_range(0, 3) < (b ? 1 : 3));
            step(r, c, rq, wq, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_param_sync.md
Name: fifo_param_sync

Overview:
Parameterised single-clock synchronous FIFO. It is the successor to the fixed 8-bit, power-of-two FIFO, and adds:
- configurable data width and any depth of 2 or more, including non-power-of-two depths;
- a first-word-fall-through (FWFT) mode;
- almost-full and almost-empty thresholds;
- an occupancy count and a high-water mark;
- sticky overflow and underflow error flags.

It sits between producer and consumer datapaths and is the standard buffering primitive for new blocks.

Parameters:
WIDTH, 8, data word width in bits (must be 1 or more).
ENTRIES, 4, storage depth (must be 2 or more; need not be a power of two).
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word is visible on out_read_data without a read.
ALMOST_FULL_TH, ENTRIES-1, out_almost_full asserts when count >= this value (legal range 1..ENTRIES).
ALMOST_EMPTY_TH, 1, out_almost_empty asserts when count <= this value (legal range 0..ENTRIES-1).

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
in_clear_err  input  1  clears the sticky error flags and re-bases the high-water mark
in_read_ctrl  input  1  read/pop request
in_write_ctrl  input  1  write/push request
in_write_data  input  WIDTH  write data
out_read_data  output  WIDTH  read data
out_read_valid  output  1  out_read_data is valid
out_is_full  output  1  count == ENTRIES
out_is_empty  output  1  count == 0
out_almost_full  output  1  count >= ALMOST_FULL_TH
out_almost_empty  output  1  count <= ALMOST_EMPTY_TH
out_count  output  CW  current occupancy; CW = $clog2(ENTRIES+1)
out_high_water  output  CW  maximum count reached since reset or clear
out_overflow  output  1  sticky flag: a write was rejected
out_underflow  output  1  sticky flag: a read was rejected

Behaviour:
- Reset (rst=1 at an edge) sets:
  - pointers and count to 0;
  - out_is_empty=1 and out_almost_empty=1;
  - out_is_full=0 and out_almost_full=0;
  - out_read_data=0 and out_read_valid=0;
  - out_high_water=0;
  - both error flags to 0.
- rst overrides all other inputs in the same cycle. Reset mid-stream discards all contents. Storage array is not reset.
- Acceptance rules:
  - rd_acc = in_read_ctrl & ~empty.
  - wr_acc = in_write_ctrl & (~full | rd_acc).
  - A write on full is accepted if a read is accepted in the same cycle (count unchanged).
  - A read on empty is rejected even if a write is accepted in the same cycle (count +1).
- Count update: count_next = count + wr_acc - rd_acc.
  - All status outputs are registered and derived from the count register, so they change on the edge that performs the access.
- Pointers increment on accept and wrap from ENTRIES-1 to 0. No reliance on power-of-two overflow.
- Write: mem[wr_ptr] <= in_write_data on wr_acc.
- FWFT=0 read path:
  - On rd_acc: out_read_data <= mem[rd_ptr] and out_read_valid <= 1 in the next cycle. Otherwise out_read_valid <= 0 and out_read_data holds its value.
  - Latency is one cycle.
  - A word written and read in the same cycle while empty is not possible, because the read is rejected.
- FWFT=1 read path:
  - out_read_data = empty ? 0 : mem[rd_ptr].
  - out_read_valid = ~out_is_empty.
  - in_read_ctrl pops the displayed word. The next word appears after the edge.
  - A written word is visible one cycle after the write, when count becomes 1.
- Errors:
  - out_overflow sets on in_write_ctrl & ~wr_acc.
  - out_underflow sets on in_read_ctrl & ~rd_acc.
  - Both flags are sticky until rst or in_clear_err.
  - If set and clear occur in the same cycle, set wins.
- High-water mark:
  - out_high_water <= max(out_high_water, count_next), updated on the same edge as out_count.
  - in_clear_err loads count_next.
- Idle cycles (no read, no write) are legal; all state holds.
- Illegal parameters (ENTRIES<2, or a threshold out of range) produce an elaboration-time $error.
- Embedded SVA (checked formally and in simulation):
  - count <= ENTRIES;
  - full and empty are never both set;
  - wr_ptr == (rd_ptr + count) mod ENTRIES;
  - cover: count reaches each value 0..ENTRIES.

Test Plan:
- ENTRIES=5, FWFT=0: reset, then write 0x11..0x55 on consecutive cycles.
  - Required: out_count 1..5; out_almost_full=1 at count 4; out_is_full=1 at count 5.
  - Then read 5 times: data 0x11..0x55, each with out_read_valid one cycle after its read; out_is_empty=1 at the end.
- Wrap-around at ENTRIES=5: run 12 write/read pairs with data 0..11.
  - Required: output order is exactly 0..11; pointers wrap 4 to 0 twice; out_high_water=1.
- Simultaneous read and write:
  - When full (count 5): both accepted; count stays 5; out_overflow stays 0.
  - When empty: write accepted, read rejected; count becomes 1; out_underflow=1.
- Overflow and clear:
  - Write while full with no read: count stays 5; out_overflow=1 until in_clear_err, then 0.
  - Assert in_clear_err in the same cycle as a new overflow: out_overflow stays 1.
- FWFT=1:
  - Write 0xA5 to an empty FIFO: out_read_data=0xA5 and out_read_valid=1 on the next cycle, with no read.
  - Read: out_read_data returns to 0 and out_is_empty=1.
- Reset mid-operation at count=3:
  - Required: the next cycle shows count 0, empty=1, high_water 0, flags 0.
  - A following write/read returns only the new data.
